// File: rtl/cu_pkg.sv
// Shared definitions for the cu_useq micro-sequencer: op encodings, FSM states
// and the microword field layout derived from the unit's parameters.
package cu_pkg;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_DISPATCH = 3'd2,
    OP_BR_SET   = 3'd3,
    OP_BR_CLR   = 3'd4,
    OP_WAIT_MEM = 3'd5,
    OP_HALT     = 3'd6,
    OP_RSVD     = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Microword layout, LSB first: op | fsel | next | ctrl
  localparam int OP_LSB   = 0;
  localparam int OP_W     = 3;
  localparam int FSEL_LSB = OP_LSB + OP_W;

  function automatic int fsel_width(input int flag_w);
    return $clog2(flag_w);
  endfunction

  function automatic int next_lsb(input int flag_w);
    return FSEL_LSB + fsel_width(flag_w);
  endfunction

  function automatic int ctrl_lsb(input int flag_w, input int uaddr_w);
    return next_lsb(flag_w) + uaddr_w;
  endfunction

  function automatic int uword_width(input int flag_w, input int uaddr_w, input int ctrl_w);
    return ctrl_lsb(flag_w, uaddr_w) + ctrl_w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cu_ucode_store.sv
// Writable table with a synchronous write port and an asynchronous read port;
// used for both the microcode store and the opcode dispatch table.
module cu_ucode_store #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // NOTE: storage arrays get no reset; contents must survive rst_n and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cu_useq.sv
// Microprogrammed control unit: run/halt FSM, next-uPC selection and table load
// guard around a loadable microcode store and opcode dispatch table.
module cu_useq
  import cu_pkg::*;
#(
  parameter int  OPC_W   = 8,
  parameter int  CTRL_W  = 32,
  parameter int  UADDR_W = 6,
  parameter int  FLAG_W  = 4,
  localparam int FSEL_W  = fsel_width(FLAG_W),
  localparam int UW_W    = uword_width(FLAG_W, UADDR_W, CTRL_W),
  localparam int LD_AW   = max_int(UADDR_W, OPC_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [OPC_W-1:0]   ir_opcode,
  input  logic               ir_valid,
  output logic               ir_ack,
  input  logic [FLAG_W-1:0]  alu_flags,
  input  logic               mem_ready,
  input  logic               ld_we,
  input  logic               ld_sel,
  input  logic [LD_AW-1:0]   ld_addr,
  input  logic [UW_W-1:0]    ld_wdata,
  output logic [CTRL_W-1:0]  Control_Signals,
  output logic [UADDR_W-1:0] upc,
  output logic               busy,
  output logic               halted,
  output logic               ld_err
);

  localparam int NEXT_LSB = next_lsb(FLAG_W);
  localparam int CTRL_LSB = ctrl_lsb(FLAG_W, UADDR_W);

  state_e               r_state;
  logic [UADDR_W-1:0]   r_upc;
  logic                 r_busy;
  logic                 r_halted;
  logic                 r_ld_err;

  logic [UW_W-1:0]      w_uword;
  logic [UADDR_W-1:0]   w_disp_upc;
  op_e                  w_op;
  logic [FSEL_W-1:0]    w_fsel;
  logic [UADDR_W-1:0]   w_next;
  logic [CTRL_W-1:0]    w_ctrl;
  logic                 w_flag;
  logic [UADDR_W-1:0]   w_upc_inc;
  logic [UADDR_W-1:0]   w_upc_nxt;
  logic                 w_fire;
  logic                 w_ack;
  logic                 w_halt_op;
  logic                 w_ld_ok;

  // Tables are writable only while the sequencer is not executing.
  assign w_ld_ok = ld_we && (r_state != ST_RUN);

  cu_ucode_store #(
    .AW (UADDR_W),
    .DW (UW_W)
  ) u_ucode (
    .clk     (clk),
    .i_we    (w_ld_ok && !ld_sel),
    .i_waddr (ld_addr[UADDR_W-1:0]),
    .i_wdata (ld_wdata),
    .i_raddr (r_upc),
    .o_rdata (w_uword)
  );

  cu_ucode_store #(
    .AW (OPC_W),
    .DW (UADDR_W)
  ) u_dispatch (
    .clk     (clk),
    .i_we    (w_ld_ok && ld_sel),
    .i_waddr (ld_addr[OPC_W-1:0]),
    .i_wdata (ld_wdata[UADDR_W-1:0]),
    .i_raddr (ir_opcode),
    .o_rdata (w_disp_upc)
  );

  assign w_op      = op_e'(w_uword[OP_LSB +: OP_W]);
  assign w_fsel    = w_uword[FSEL_LSB +: FSEL_W];
  assign w_next    = w_uword[NEXT_LSB +: UADDR_W];
  assign w_ctrl    = w_uword[CTRL_LSB +: CTRL_W];
  assign w_upc_inc = r_upc + UADDR_W'(1);

  // A select beyond the implemented flags falls back to flag 0.
  assign w_flag = (int'(w_fsel) < FLAG_W) ? alu_flags[w_fsel] : alu_flags[0];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_fire    = 1'b0;
    w_ack     = 1'b0;
    w_halt_op = 1'b0;
    w_upc_nxt = r_upc;
    if (r_state == ST_RUN) begin
      case (w_op)
        OP_JUMP: begin
          w_fire    = 1'b1;
          w_upc_nxt = w_next;
        end
        OP_DISPATCH: begin
          if (ir_valid) begin
            w_fire    = 1'b1;
            w_ack     = 1'b1;
            w_upc_nxt = w_disp_upc;
          end
        end
        OP_BR_SET: begin
          w_fire    = 1'b1;
          w_upc_nxt = w_flag ? w_next : w_upc_inc;
        end
        OP_BR_CLR: begin
          w_fire    = 1'b1;
          w_upc_nxt = w_flag ? w_upc_inc : w_next;
        end
        OP_WAIT_MEM: begin
          if (mem_ready) begin
            w_fire    = 1'b1;
            w_upc_nxt = w_upc_inc;
          end
        end
        OP_HALT: begin
          w_fire    = 1'b1;
          w_halt_op = 1'b1;
        end
        default: begin
          w_fire    = 1'b1;
          w_upc_nxt = w_upc_inc;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_upc    <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= ld_we && (r_state == ST_RUN);
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            r_state  <= ST_RUN;
            r_upc    <= '0;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        ST_RUN: begin
          r_upc <= w_upc_nxt;
          if (w_halt_op) begin
            r_state  <= ST_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign Control_Signals = w_fire ? w_ctrl : '0;
  assign ir_ack          = w_ack;
  assign upc             = r_upc;
  assign busy            = r_busy;
  assign halted          = r_halted;
  assign ld_err          = r_ld_err;

endmodule

// File: tb/tb_cu_useq.sv
// Self-checking bench for cu_useq: vector table of per-cycle stimulus and
// expected outputs, scoreboarded through a queue, plus a mid-run reset sequence.
module tb_cu_useq;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  ir_opcode;
  logic        ir_valid;
  logic        ir_ack;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        ld_we;
  logic        ld_sel;
  logic [7:0]  ld_addr;
  logic [42:0] ld_wdata;
  logic [31:0] ctrl_sig;
  logic [5:0]  upc;
  logic        busy;
  logic        halted;
  logic        ld_err;

  always #5 clk = ~clk;

  cu_useq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .ir_opcode       (ir_opcode),
    .ir_valid        (ir_valid),
    .ir_ack          (ir_ack),
    .alu_flags       (alu_flags),
    .mem_ready       (mem_ready),
    .ld_we           (ld_we),
    .ld_sel          (ld_sel),
    .ld_addr         (ld_addr),
    .ld_wdata        (ld_wdata),
    .Control_Signals (ctrl_sig),
    .upc             (upc),
    .busy            (busy),
    .halted          (halted),
    .ld_err          (ld_err)
  );

  typedef struct packed {
    logic        start;
    logic        ir_valid;
    logic [7:0]  opc;
    logic [3:0]  flags;
    logic        mem_ready;
    logic        ld_we;
    logic        ld_sel;
    logic [7:0]  ld_addr;
    logic [42:0] ld_wdata;
    logic [31:0] e_ctrl;
    logic [5:0]  e_upc;
    logic        e_ack;
    logic        e_busy;
    logic        e_halted;
    logic        e_ld_err;
  } vec_t;

  typedef logic [41:0] obs_t;

  vec_t vq[$];
  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [42:0] mk(input logic [2:0] op, input logic [1:0] fs,
                                     input logic [5:0] nx, input logic [31:0] c);
    return {c, nx, fs, op};
  endfunction

  function automatic obs_t observe();
    return {ctrl_sig, upc, ir_ack, busy, halted, ld_err};
  endfunction

  task automatic add(input logic st, input logic iv, input logic [7:0] opc, input logic [3:0] fl,
                     input logic mr, input logic we, input logic sel, input logic [7:0] la,
                     input logic [42:0] wd, input logic [31:0] ec, input logic [5:0] eu,
                     input logic ea, input logic eb, input logic eh, input logic el);
    vec_t t;
    t = '{st, iv, opc, fl, mr, we, sel, la, wd, ec, eu, ea, eb, eh, el};
    vq.push_back(t);
  endtask

  // Table write while stopped at (upc, halted).
  task automatic ld(input logic sel, input logic [7:0] a, input logic [42:0] d,
                    input logic [5:0] u, input logic h);
    add(0, 0, 0, 0, 0, 1, sel, a, d, 0, u, 0, 0, h, 0);
  endtask

  task automatic st(input logic [5:0] u, input logic h);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, u, 0, 0, h, 0);
  endtask

  task automatic rn(input logic iv, input logic [7:0] opc, input logic [3:0] fl, input logic mr,
                    input logic [31:0] ec, input logic [5:0] eu, input logic ea);
    add(0, iv, opc, fl, mr, 0, 0, 0, 0, ec, eu, ea, 1, 0, 0);
  endtask

  task automatic hl(input logic [5:0] u);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, u, 0, 0, 1, 0);
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    ir_valid  = 1'b0;
    ir_opcode = '0;
    alu_flags = '0;
    mem_ready = 1'b0;
    ld_we     = 1'b0;
    ld_sel    = 1'b0;
    ld_addr   = '0;
    ld_wdata  = '0;
  endtask

  task automatic run_vectors(input string tag);
    int idx = 0;
    while (vq.size() > 0) begin
      vec_t v;
      v = vq.pop_front();
      @(negedge clk);
      start     = v.start;
      ir_valid  = v.ir_valid;
      ir_opcode = v.opc;
      alu_flags = v.flags;
      mem_ready = v.mem_ready;
      ld_we     = v.ld_we;
      ld_sel    = v.ld_sel;
      ld_addr   = v.ld_addr;
      ld_wdata  = v.ld_wdata;
      exp_q.push_back({v.e_ctrl, v.e_upc, v.e_ack, v.e_busy, v.e_halted, v.e_ld_err});
      #1;
      check($sformatf("%s[%0d] {ctrl,upc,ack,busy,halted,ld_err}", tag, idx),
            64'(observe()), 64'(exp_q.pop_front()));
      idx++;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset state", 64'(observe()), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line NEXT words ending in HALT
    ld(0, 8'h00, mk(OP_NEXT, 0, 0, 32'h1), 0, 0);
    ld(0, 8'h01, mk(OP_NEXT, 0, 0, 32'h2), 0, 0);
    ld(0, 8'h02, mk(OP_NEXT, 0, 0, 32'h4), 0, 0);
    ld(0, 8'h03, mk(OP_HALT, 0, 0, 32'h8), 0, 0);
    st(0, 0);
    rn(0, 0, 0, 0, 32'h1, 6'h00, 0);
    rn(0, 0, 0, 0, 32'h2, 6'h01, 0);
    rn(0, 0, 0, 0, 32'h4, 6'h02, 0);
    rn(0, 0, 0, 0, 32'h8, 6'h03, 0);
    hl(6'h03);
    run_vectors("seq");

    // Dispatch with ir_valid stalls
    ld(0, 8'h00, mk(OP_DISPATCH, 0, 0, 32'hD1), 6'h03, 1);
    ld(1, 8'hA5, 43'h10, 6'h03, 1);
    ld(1, 8'h5A, 43'h33, 6'h03, 1);
    ld(0, 8'h10, mk(OP_HALT, 0, 0, 32'h99), 6'h03, 1);
    st(6'h03, 1);
    rn(0, 8'hA5, 0, 0, 32'h0, 6'h00, 0);
    rn(0, 8'hA5, 0, 0, 32'h0, 6'h00, 0);
    rn(0, 8'hA5, 0, 0, 32'h0, 6'h00, 0);
    rn(1, 8'hA5, 0, 0, 32'hD1, 6'h00, 1);
    rn(0, 0, 0, 0, 32'h99, 6'h10, 0);
    hl(6'h10);
    run_vectors("disp");

    // BR_SET / BR_CLR on flag 2; word 0x20 written in the same cycle as start
    ld(0, 8'h00, mk(OP_JUMP, 0, 6'h05, 32'h100), 6'h10, 1);
    ld(0, 8'h05, mk(OP_BR_SET, 2, 6'h20, 32'h200), 6'h10, 1);
    ld(0, 8'h06, mk(OP_HALT, 0, 0, 32'h600), 6'h10, 1);
    add(1, 0, 0, 0, 0, 1, 0, 8'h20, mk(OP_HALT, 0, 0, 32'h2000), 0, 6'h10, 0, 0, 1, 0);
    rn(0, 0, 4'b0000, 0, 32'h100, 6'h00, 0);
    rn(0, 0, 4'b0100, 0, 32'h200, 6'h05, 0);
    rn(0, 0, 4'b0000, 0, 32'h2000, 6'h20, 0);
    hl(6'h20);
    st(6'h20, 1);
    rn(0, 0, 4'b0000, 0, 32'h100, 6'h00, 0);
    rn(0, 0, 4'b0000, 0, 32'h200, 6'h05, 0);
    rn(0, 0, 4'b0000, 0, 32'h600, 6'h06, 0);
    hl(6'h06);
    ld(0, 8'h05, mk(OP_BR_CLR, 2, 6'h20, 32'h400), 6'h06, 1);
    st(6'h06, 1);
    rn(0, 0, 4'b0000, 0, 32'h100, 6'h00, 0);
    rn(0, 0, 4'b0100, 0, 32'h400, 6'h05, 0);
    rn(0, 0, 4'b0000, 0, 32'h600, 6'h06, 0);
    hl(6'h06);
    st(6'h06, 1);
    rn(0, 0, 4'b0000, 0, 32'h100, 6'h00, 0);
    rn(0, 0, 4'b1011, 0, 32'h400, 6'h05, 0);
    rn(0, 0, 4'b0000, 0, 32'h2000, 6'h20, 0);
    hl(6'h20);
    run_vectors("br");

    // WAIT_MEM stalls, uPC wrap, start ignored in RUN, rejected write in RUN
    ld(0, 8'h00, mk(OP_JUMP, 0, 6'h07, 32'h1), 6'h20, 1);
    ld(0, 8'h07, mk(OP_WAIT_MEM, 0, 0, 32'h777), 6'h20, 1);
    ld(0, 8'h08, mk(OP_JUMP, 0, 6'h12, 32'h888), 6'h20, 1);
    ld(0, 8'h12, mk(OP_JUMP, 0, 6'h3F, 32'h1212), 6'h20, 1);
    ld(0, 8'h3F, mk(OP_NEXT, 0, 0, 32'h3F3F), 6'h20, 1);
    st(6'h20, 1);
    rn(0, 0, 0, 0, 32'h1, 6'h00, 0);
    rn(0, 0, 0, 0, 32'h0, 6'h07, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'h07, 0, 1, 0, 0);
    rn(0, 0, 0, 1, 32'h777, 6'h07, 0);
    rn(0, 0, 0, 0, 32'h888, 6'h08, 0);
    rn(0, 0, 0, 0, 32'h1212, 6'h12, 0);
    rn(0, 0, 0, 0, 32'h3F3F, 6'h3F, 0);
    rn(0, 0, 0, 0, 32'h1, 6'h00, 0);
    add(0, 0, 0, 0, 0, 1, 0, 8'h07, mk(OP_HALT, 0, 0, 32'hBAD), 32'h0, 6'h07, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'h07, 0, 1, 0, 1);
    rn(0, 0, 0, 0, 32'h0, 6'h07, 0);
    rn(0, 0, 0, 1, 32'h777, 6'h07, 0);
    rn(0, 0, 0, 0, 32'h888, 6'h08, 0);
    run_vectors("wait");

    // Reset mid-run at uPC 0x12, then replay the surviving microcode
    @(negedge clk);
    #1;
    check("pre-reset {upc,busy,ctrl}", 64'({upc, busy, ctrl_sig}), 64'({6'h12, 1'b1, 32'h1212}));
    rst_n = 1'b0;
    #1;
    check("async reset {upc,busy,halted,ctrl,ack}",
          64'({upc, busy, halted, ctrl_sig, ir_ack}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    st(6'h00, 0);
    rn(0, 0, 0, 0, 32'h1, 6'h00, 0);
    rn(0, 0, 0, 0, 32'h0, 6'h07, 0);
    rn(0, 0, 0, 1, 32'h777, 6'h07, 0);
    rn(0, 0, 0, 0, 32'h888, 6'h08, 0);
    rn(0, 0, 0, 0, 32'h1212, 6'h12, 0);
    run_vectors("replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_useq.md
# cu_useq

Parametrised microprogrammed control unit for the BitCruncher datapath. It replaces the fixed 8-bit-opcode / 32-bit-control CU with a loadable micro-sequencer:
- a writable microcode store and a writable opcode dispatch table;
- conditional branching on ALU flags;
- instruction-fetch and memory-wait handshakes;
- an explicit run/halt state machine.

It sits between the instruction register and the datapath and drives every datapath control line.

## Interface
Parameters:
- OPC_W, 8: opcode width; the dispatch table holds 2^OPC_W entries.
- CTRL_W, 32: control word width.
- UADDR_W, 6: micro-address width; the microcode store holds 2^UADDR_W words.
- FLAG_W, 4: ALU flag count.
- Derived localparams:
  - FSEL_W = $clog2(FLAG_W)
  - UW_W = 3+FSEL_W+UADDR_W+CTRL_W
  - LD_AW = max(UADDR_W,OPC_W)

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution at uPC 0 from IDLE or HALT.
- ir_opcode  in  OPC_W  current instruction opcode.
- ir_valid  in  1  ir_opcode is valid.
- ir_ack  out  1  opcode consumed this cycle.
- alu_flags  in  FLAG_W  ALU status flags.
- mem_ready  in  1  memory access complete.
- ld_we  in  1  table write strobe.
- ld_sel  in  1  write target: 0 = microcode store, 1 = dispatch table.
- ld_addr  in  LD_AW  write address; the low bits are used per target.
- ld_wdata  in  UW_W  write data; the dispatch table takes the low UADDR_W bits.
- Control_Signals  out  CTRL_W  datapath control word.
- upc  out  UADDR_W  current micro-PC.
- busy  out  1  state is RUN.
- halted  out  1  state is HALT.
- ld_err  out  1  one-cycle pulse on a write rejected in RUN.

## Operation
- Microword fields, LSB first:
  - op[2:0]
  - fsel[FSEL_W-1:0]
  - next[UADDR_W-1:0]
  - ctrl[CTRL_W-1:0]
- FSM states:
  - IDLE: reset state.
    - start -> RUN with upc=0.
  - RUN: executes the word at mem[upc] each cycle.
    - HALT op -> HALT.
  - HALT:
    - start -> RUN with upc=0.
- Ops, with the resulting upc at the edge; "fires" means Control_Signals = ctrl this cycle:
  - 0 NEXT: upc+1, wrapping from 2^UADDR_W-1 to 0. Fires.
  - 1 JUMP: upc = next. Fires.
  - 2 DISPATCH:
    - If ir_valid: fires, ir_ack=1, and upc = disp[ir_opcode].
    - Else: Control_Signals=0, ir_ack=0, upc held.
  - 3 BR_SET: upc = next if alu_flags[fsel]=1, else upc+1. Fires.
  - 4 BR_CLR: upc = next if alu_flags[fsel]=0, else upc+1. Fires.
  - 5 WAIT_MEM:
    - If mem_ready: fires and upc+1.
    - Else: Control_Signals=0 and upc held.
  - 6 HALT: fires for one cycle, then the state goes to HALT and upc is held.
  - 7: reserved and behaves exactly as NEXT.
- Loads:
  - A write is accepted in IDLE or HALT and takes effect at the edge.
  - A write in RUN is ignored, and ld_err pulses high the next cycle.
  - Writes and start in the same cycle: the write is accepted, because the state is not yet RUN.
- Reset:
  - upc=0 and the state goes to IDLE, including when reset hits mid-RUN.
  - The microcode store and dispatch table are not reset; their contents survive rst_n.
- An out-of-range fsel (at or above FLAG_W) reads as flag 0.

## Timing
- Reset values:
  - Control_Signals=0
  - ir_ack=0
  - upc=0
  - busy=0
  - halted=0
  - ld_err=0
- Control_Signals and ir_ack are combinational from mem[upc], state, ir_valid and mem_ready. They are 0 outside RUN.
- The fetch is zero-latency: the word is read asynchronously at upc.
- Flags and the opcode are sampled at the rising edge that ends the cycle of the branch or dispatch word.
- One microword executes per cycle. There is no pipeline bubble after a taken branch.
- Stall cycles (DISPATCH without ir_valid, WAIT_MEM without mem_ready) never assert Control_Signals. Each ctrl therefore fires exactly once.
- start in RUN is ignored.
- ld_err is registered, with 1-cycle latency.

## Structure
- Package cu_pkg holds:
  - the op encodings as an enum;
  - the field offset and width localparam functions for the given parameters.
- Sub-module cu_ucode_store: a parametrised synchronous-write, asynchronous-read array. It is instantiated twice, once for the microcode store and once for the dispatch table.
- The top level contains the FSM, the next-upc mux and the load guard.

## Test plan
- Load NEXT words at 0..2 with ctrl=0x1, 0x2, 0x4 and HALT at 3 with ctrl=0x8, then pulse start.
  - Required: Control_Signals is 1,2,4,8 on consecutive cycles.
  - Then halted=1 and Control_Signals=0.
- Word 0 is DISPATCH, and disp[0xA5]=0x10. Hold ir_valid=0 for 3 cycles, then drive 0xA5 with ir_valid=1.
  - Required: upc=0 and ctrl=0 for 3 cycles.
  - Then ir_ack=1 for one cycle, and the next upc=0x10.
- BR_SET with fsel=2 and next=0x20 at upc 5.
  - Required: alu_flags=4'b0100 -> upc=0x20; alu_flags=4'b0000 -> upc=6.
  - BR_CLR with the same operands gives the inverse result.
- WAIT_MEM at 7 with mem_ready low for 2 cycles, then high.
  - Required: ctrl=0 for 2 cycles, then ctrl fires once and upc=8.
  - NEXT at 0x3F: required upc wraps to 0.
- Attempt ld_we in RUN.
  - Required: ld_err pulses, and a later readback via execution shows the old word.
- Assert rst_n low mid-RUN at upc=0x12.
  - Required: immediately upc=0, busy=0 and ctrl=0.
  - A following start replays the unchanged microcode.
